// File: rtl/song_pkg.sv
// Shared song entry layout, reader state encoding and the rest-note constant.
package song_pkg;

   // Default field widths of one song RAM entry (shared with the recorder).
   localparam int NOTE_W   = 6;
   localparam int DUR_W    = 6;

   // Entry layout: {end_flag, note, duration}, duration in the low bits.
   localparam int DUR_LSB  = 0;
   localparam int DUR_MSB  = DUR_LSB + DUR_W - 1;
   localparam int NOTE_LSB = DUR_MSB + 1;
   localparam int NOTE_MSB = NOTE_LSB + NOTE_W - 1;
   localparam int END_BIT  = NOTE_MSB + 1;
   localparam int ENTRY_W  = END_BIT + 1;

   // Note index 0 is a rest.
   localparam logic [NOTE_W-1:0] REST_NOTE = '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_PLAY,
      S_PAUSED
   } reader_state_t;

endpackage

// File: rtl/song_reader_beat_countdown.sv
// Beat countdown for the note being played: loaded with the duration,
// decremented on each enabled beat, flags the beat that ends the note.
module beat_countdown #(
   parameter int DUR_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DUR_WIDTH-1:0] load_val,
   input  logic                 beat,
   input  logic                 enable,
   output logic [DUR_WIDTH-1:0] count,
   output logic                 expire
);

   // The beat that takes the count from 1 to 0 is the last beat of the note.
   assign expire = enable && beat && (count == DUR_WIDTH'(1));

   // Counter register; load wins over counting, and it never wraps below 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (enable && beat && (count != '0))
         count <= count - DUR_WIDTH'(1);
   end

endmodule

// File: rtl/song_reader.sv
// Playback sequencer: walks the song RAM, presents each note to the note
// player and holds it for its recorded number of beats.
module song_reader
   import song_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int NOTE_WIDTH = NOTE_W,
   parameter int DUR_WIDTH  = DUR_W
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              play_pulse,
   input  logic                              stop_pulse,
   input  logic                              beat,
   output logic [ADDR_WIDTH-1:0]             ram_addr,
   input  logic [NOTE_WIDTH+DUR_WIDTH:0]     ram_dout,
   output logic [NOTE_WIDTH-1:0]             note_out,
   output logic                              note_active,
   output logic                              note_start,
   output logic                              song_done,
   output logic                              playing
);

   // Field positions derived from the actual parameter values, so the
   // layout tracks any width override while matching the package defaults.
   localparam int EB = NOTE_WIDTH + DUR_WIDTH;

   reader_state_t           state, state_n;
   logic [ADDR_WIDTH-1:0]   addr_n;
   logic [NOTE_WIDTH-1:0]   note_n;
   logic                    active_n, start_n, done_n, playing_n;

   logic                    cnt_load, cnt_en, cnt_expire, note_end;
   logic [DUR_WIDTH-1:0]    cnt_val, cnt;

   logic                    entry_end;
   logic [NOTE_WIDTH-1:0]   entry_note;
   logic [DUR_WIDTH-1:0]    entry_dur;

   assign entry_end  = ram_dout[EB] || (ram_dout[DUR_WIDTH-1:0] == '0);
   assign entry_note = ram_dout[EB-1:DUR_WIDTH];
   assign entry_dur  = ram_dout[DUR_WIDTH-1:0];

   // A zero count in PLAY cannot follow a valid DECODE; treating it as an
   // ended note keeps the reader from ever sticking in PLAY.
   assign note_end = cnt_expire || (cnt == '0);

   beat_countdown #(.DUR_WIDTH(DUR_WIDTH)) u_count (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .beat     (beat),
      .enable   (cnt_en),
      .count    (cnt),
      .expire   (cnt_expire)
   );

   // Next-state and next-output decode; stop overrides every other event.
   always_comb begin
      state_n  = state;
      addr_n   = ram_addr;
      note_n   = note_out;
      active_n = note_active;
      start_n  = 1'b0;
      done_n   = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = entry_dur;
      cnt_en   = 1'b0;
      if (stop_pulse) begin
         state_n  = S_IDLE;
         addr_n   = '0;
         note_n   = NOTE_WIDTH'(REST_NOTE);
         active_n = 1'b0;
         cnt_load = 1'b1;
         cnt_val  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (play_pulse)
                  state_n = S_FETCH;
            end
            S_FETCH: begin
               // RAM is sampling ram_addr this cycle.
               state_n = S_DECODE;
            end
            S_DECODE: begin
               if (entry_end) begin
                  done_n   = 1'b1;
                  addr_n   = '0;
                  note_n   = NOTE_WIDTH'(REST_NOTE);
                  active_n = 1'b0;
                  state_n  = S_IDLE;
               end else begin
                  note_n   = entry_note;
                  cnt_load = 1'b1;
                  start_n  = 1'b1;
                  active_n = 1'b1;
                  state_n  = S_PLAY;
               end
            end
            S_PLAY: begin
               if (play_pulse) begin
                  // Pause takes precedence over a coincident beat.
                  active_n = 1'b0;
                  state_n  = S_PAUSED;
               end else begin
                  cnt_en = 1'b1;
                  if (note_end) begin
                     active_n = 1'b0;
                     if (&ram_addr) begin
                        // Running off the top of the RAM ends the song.
                        done_n  = 1'b1;
                        addr_n  = '0;
                        note_n  = NOTE_WIDTH'(REST_NOTE);
                        state_n = S_IDLE;
                     end else begin
                        addr_n  = ram_addr + ADDR_WIDTH'(1);
                        state_n = S_FETCH;
                     end
                  end
               end
            end
            S_PAUSED: begin
               if (play_pulse) begin
                  active_n = 1'b1;
                  state_n  = S_PLAY;
               end
            end
            default: begin
               state_n  = S_IDLE;
               addr_n   = '0;
               note_n   = NOTE_WIDTH'(REST_NOTE);
               active_n = 1'b0;
            end
         endcase
      end
      playing_n = (state_n != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         ram_addr    <= '0;
         note_out    <= '0;
         note_active <= 1'b0;
         note_start  <= 1'b0;
         song_done   <= 1'b0;
         playing     <= 1'b0;
      end else begin
         state       <= state_n;
         ram_addr    <= addr_n;
         note_out    <= note_n;
         note_active <= active_n;
         note_start  <= start_n;
         song_done   <= done_n;
         playing     <= playing_n;
      end
   end

endmodule

// File: tb/tb_song_reader.sv
// Randomised scoreboard bench for song_reader: a reference model turns the
// RAM image into the expected list of notes/end-of-song, a monitor checks it.
module tb_song_reader;

   localparam int AW = 7;
   localparam int NW = 6;
   localparam int DW = 6;
   localparam int EW = NW + DW + 1;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic play_pulse = 1'b0;
   logic stop_pulse = 1'b0;
   logic beat = 1'b0;
   logic [AW-1:0] ram_addr;
   logic [EW-1:0] ram_dout = '0;
   logic [NW-1:0] note_out;
   logic note_active, note_start, song_done, playing;

   logic [EW-1:0] mem [0:DEPTH-1];

   song_reader #(.ADDR_WIDTH(AW), .NOTE_WIDTH(NW), .DUR_WIDTH(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .play_pulse  (play_pulse),
      .stop_pulse  (stop_pulse),
      .beat        (beat),
      .ram_addr    (ram_addr),
      .ram_dout    (ram_dout),
      .note_out    (note_out),
      .note_active (note_active),
      .note_start  (note_start),
      .song_done   (song_done),
      .playing     (playing)
   );

   always #5 clk = ~clk;

   // Synchronous-read song RAM.
   always @(posedge clk) ram_dout <= mem[ram_addr];

   typedef struct {
      bit done;
      int note;
      int dur;
   } exp_t;

   exp_t exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   bit open = 1'b0;
   int open_dur = 0;
   int beats_seen = 0;
   int beat_total = 0;
   int beat_period = 4;
   int tick = 0;
   bit beat_en = 1'b0;
   bit man_beat = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [EW-1:0] ent(input int e, input int n, input int d);
      logic [EW-1:0] r;
      r = {e[0], n[NW-1:0], d[DW-1:0]};
      return r;
   endfunction

   // Reference model: the song is the run of entries from address 0 up to
   // the first end marker, or to the top of the RAM, followed by one done.
   task automatic build_expected();
      exp_t x;
      for (int a = 0; a < DEPTH; a++) begin
         if (mem[a][EW-1] || mem[a][DW-1:0] == 0) begin
            x.done = 1; x.note = 0; x.dur = 0;
            exp_q.push_back(x);
            return;
         end
         x.done = 0; x.note = int'(mem[a][EW-2:DW]); x.dur = int'(mem[a][DW-1:0]);
         exp_q.push_back(x);
      end
      x.done = 1; x.note = 0; x.dur = 0;
      exp_q.push_back(x);
   endtask

   task automatic close_note();
      if (open) begin
         chk("note_beats", beats_seen, open_dur);
         open = 1'b0;
      end
   endtask

   task automatic flush();
      exp_q.delete();
      open = 1'b0;
   endtask

   // Monitor: pops the expected event whenever the DUT starts a note or ends
   // the song, and counts the beats that fall inside a sounding note.
   always @(negedge clk) begin : mon
      exp_t x;
      if (!reset) begin
         if (song_done) begin
            close_note();
            if (exp_q.size() == 0) chk("unexpected_song_done", 1, 0);
            else begin
               x = exp_q.pop_front();
               chk("event_is_done", 1, x.done);
            end
            chk("done_ram_addr", ram_addr, 0);
            chk("done_note_active", note_active, 0);
         end
         if (note_start) begin
            close_note();
            if (exp_q.size() == 0) chk("unexpected_note_start", 1, 0);
            else begin
               x = exp_q.pop_front();
               chk("event_is_note", 0, x.done);
               chk("note_value", note_out, x.note);
               open = 1'b1;
               open_dur = x.dur;
               beats_seen = 0;
            end
            chk("active_at_start", note_active, 1);
         end
         if (open && note_active && beat && !play_pulse && !stop_pulse)
            beats_seen++;
      end
   end

   // Beat generator; never fires alongside a play/stop pulse unless the
   // collision is forced through man_beat.
   initial begin
      forever begin
         bit gen;
         @(posedge clk);
         #2;
         if (beat_en) tick++;
         gen = beat_en && (tick >= beat_period) && !play_pulse && !stop_pulse;
         if (gen) tick = 0;
         beat = gen || man_beat;
         if (beat) beat_total++;
      end
   end

   task automatic pulse_play();
      @(posedge clk); #1 play_pulse = 1'b1;
      @(posedge clk); #1 play_pulse = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string name);
      int c;
      c = 0;
      while (playing === 1'b1 && c < maxc) begin
         @(negedge clk);
         c++;
      end
      chk({name, "_finished"}, (c < maxc), 1);
      @(negedge clk);
      @(negedge clk);
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   // Wait (bounded) for mid-note PLAY, optionally at a given address.
   task automatic wait_mid_note(input int addr, input string name);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(note_active && !note_start && (addr < 0 || ram_addr == addr)) && c < 2000);
      chk({name, "_reached"}, (c < 2000), 1);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int bt0;
      int c;
      for (int a = 0; a < DEPTH; a++) mem[a] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_note_out", note_out, 0);
      chk("rst_note_active", note_active, 0);
      chk("rst_note_start", note_start, 0);
      chk("rst_song_done", song_done, 0);
      chk("rst_playing", playing, 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      // Basic play with latency checks
      mem[0] = ent(0, 12, 2); mem[1] = ent(0, 15, 1); mem[2] = ent(1, 0, 0);
      build_expected();
      beat_period = 20; tick = 0; beat_en = 1'b1;
      @(posedge clk); #1 play_pulse = 1'b1;
      @(posedge clk); #1 play_pulse = 1'b0;
      @(negedge clk);
      chk("lat_fetch_playing", playing, 1);
      chk("lat_fetch_addr", ram_addr, 0);
      chk("lat_fetch_start", note_start, 0);
      @(negedge clk);
      chk("lat_decode_start", note_start, 0);
      @(negedge clk);
      chk("lat_note_start", note_start, 1);
      chk("lat_note_active", note_active, 1);
      wait_idle(3000, "basic");

      // Random songs: mixed notes (rests included), durations and end markers
      for (int s = 0; s < 6; s++) begin
         n = $urandom_range(10, 1);
         for (int a = 0; a < n; a++)
            mem[a] = ent(0, $urandom_range(63, 0), $urandom_range(4, 1));
         mem[n] = ($urandom_range(1, 0) == 1) ? ent(1, $urandom_range(63, 0), $urandom_range(63, 0))
                                              : ent(0, $urandom_range(63, 0), 0);
         beat_period = $urandom_range(6, 1);
         build_expected();
         pulse_play();
         wait_idle(3000, "random_song");
      end

      // Pause after 1 of 3 beats, 5 beats while paused, resume
      mem[0] = ent(0, 9, 3); mem[1] = ent(1, 0, 0);
      beat_period = 6;
      build_expected();
      pulse_play();
      c = 0;
      do begin @(negedge clk); c++; end while (!(open && beats_seen == 1) && c < 500);
      chk("pause_point_reached", (c < 500), 1);
      pulse_play();
      bt0 = beat_total;
      c = 0;
      while (beat_total < bt0 + 5 && c < 500) begin
         @(negedge clk);
         chk("paused_note_active", note_active, 0);
         chk("paused_playing", playing, 1);
         c++;
      end
      pulse_play();
      @(negedge clk);
      chk("resume_active", note_active, 1);
      chk("resume_no_start", note_start, 0);
      wait_idle(2000, "pause");

      // Stop mid-note at address 4, then restart from address 0
      for (int a = 0; a < 8; a++) mem[a] = ent(0, $urandom_range(63, 1), 3);
      mem[8] = ent(1, 0, 0);
      beat_period = 4;
      build_expected();
      pulse_play();
      wait_mid_note(4, "stop");
      @(posedge clk); #1 stop_pulse = 1'b1; flush();
      @(posedge clk); #1 stop_pulse = 1'b0;
      @(negedge clk);
      chk("stop_playing", playing, 0);
      chk("stop_ram_addr", ram_addr, 0);
      chk("stop_note_out", note_out, 0);
      chk("stop_note_active", note_active, 0);
      chk("stop_song_done", song_done, 0);
      repeat (3) @(negedge clk);
      build_expected();
      pulse_play();
      wait_idle(3000, "restart");

      // Wrap-around: full RAM, no end marker
      for (int a = 0; a < DEPTH; a++) mem[a] = ent(0, a % 64, 1);
      beat_period = 2;
      build_expected();
      pulse_play();
      wait_idle(5000, "wrap");

      // stop + play collision in PLAY
      for (int a = 0; a < DEPTH; a++) mem[a] = '0;
      mem[0] = ent(0, 20, 3); mem[1] = ent(0, 21, 2); mem[2] = ent(1, 0, 0);
      beat_period = 5;
      build_expected();
      pulse_play();
      wait_mid_note(-1, "stop_play");
      @(posedge clk); #1 stop_pulse = 1'b1; play_pulse = 1'b1; flush();
      @(posedge clk); #1 stop_pulse = 1'b0; play_pulse = 1'b0;
      @(negedge clk);
      chk("stop_play_idle", playing, 0);
      chk("stop_play_done", song_done, 0);

      // beat + play collision in PLAY: beat dropped, state paused
      beat_en = 1'b0;
      repeat (2) @(negedge clk);
      build_expected();
      pulse_play();
      wait_mid_note(-1, "beat_play");
      @(posedge clk); #1 man_beat = 1'b1; play_pulse = 1'b1;
      @(posedge clk); #1 man_beat = 1'b0; play_pulse = 1'b0;
      @(negedge clk);
      chk("beat_play_paused", playing, 1);
      chk("beat_play_inactive", note_active, 0);
      pulse_play();
      tick = 0; beat_en = 1'b1;
      wait_idle(3000, "beat_play");

      // Asynchronous reset mid-note
      build_expected();
      pulse_play();
      wait_mid_note(-1, "async_rst");
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_ram_addr", ram_addr, 0);
      chk("arst_note_out", note_out, 0);
      chk("arst_note_active", note_active, 0);
      chk("arst_note_start", note_start, 0);
      chk("arst_song_done", song_done, 0);
      chk("arst_playing", playing, 0);
      flush();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("arst_stays_idle", playing, 0);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
